// File: rtl/debounce_pkg.sv
// Shared types and elaboration helpers for the debounce_edge conditioning stage.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_e;

  // The counter only needs to reach cycles-1, but the width must hold the full count.
  function automatic bit cnt_w_ok(input int cnt_w, input int cycles);
    if (cnt_w < 1 || cnt_w > 62) return 1'b0;
    return (longint'(1) << cnt_w) > longint'(cycles);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop pin synchroniser; reset clears every stage to 0.
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] s;

  always_ff @(posedge clk) begin
    if (reset) s <= '0;
    else       s <= {s[SYNC_STAGES-2:0], i_d};
  end

  assign o_q = s[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// Synchronise a raw bit, accept a new level only after DEBOUNCE_CYCLES stable
// samples, and emit one-cycle rise/fall strobes on each accepted change.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_busy
);

  generate
    if (!cnt_w_ok(CNT_W, DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
      $fatal(1, "debounce_edge: CNT_W too small for DEBOUNCE_CYCLES");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $fatal(1, "debounce_edge: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
      $fatal(1, "debounce_edge: DEBOUNCE_CYCLES must be >= 2");
    end
  endgenerate

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic             sync;
  state_e           state;
  logic [CNT_W-1:0] cnt;

  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .i_d   (i_raw),
    .o_q   (sync)
  );

  // The first differing sample already counts as sample 1, so acceptance
  // happens on the edge where cnt == DEBOUNCE_CYCLES-1 and the sample still holds.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE_LO;
      cnt    <= '0;
      o_rise <= 1'b0;
      o_fall <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      o_fall <= 1'b0;
      case (state)
        IDLE_LO: if (i_en && sync) begin
          state <= WAIT_HI;
          cnt   <= ONE;
        end
        WAIT_HI: begin
          if (!i_en || !sync) begin
            state <= IDLE_LO;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state  <= IDLE_HI;
            cnt    <= '0;
            o_rise <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        IDLE_HI: if (i_en && !sync) begin
          state <= WAIT_LO;
          cnt   <= ONE;
        end
        WAIT_LO: begin
          if (!i_en || sync) begin
            state <= IDLE_HI;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state  <= IDLE_LO;
            cnt    <= '0;
            o_fall <= 1'b1;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= IDLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level = (state == IDLE_HI) || (state == WAIT_LO);
  assign o_busy  = (state == WAIT_HI) || (state == WAIT_LO);

endmodule

// File: tb/tb_debounce_edge.sv
// Directed checks of debounce_edge with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_debounce_edge;
  import debounce_pkg::*;

  logic clk = 1'b0;
  logic reset, i_en, i_raw;
  logic o_level, o_rise, o_fall, o_busy;
  int   total = 0;
  int   bad   = 0;
  int   busy_seen;

  debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_en    (i_en),
    .i_raw   (i_raw),
    .o_level (o_level),
    .o_rise  (o_rise),
    .o_fall  (o_fall),
    .o_busy  (o_busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic lvl, input logic r,
                         input logic f, input logic b);
    chk({tag, ".level"}, {7'd0, o_level}, {7'd0, lvl});
    chk({tag, ".rise"},  {7'd0, o_rise},  {7'd0, r});
    chk({tag, ".fall"},  {7'd0, o_fall},  {7'd0, f});
    chk({tag, ".busy"},  {7'd0, o_busy},  {7'd0, b});
  endtask

  task automatic chk_st(input string tag, input state_e st, input int c);
    chk({tag, ".state"}, 8'(dut.state), 8'(st));
    chk({tag, ".cnt"},   8'(dut.cnt),   8'(c));
  endtask

  initial begin
    reset = 1'b1; i_en = 1'b1; i_raw = 1'b1;
    step(3);
    chk_out("rst", 0, 0, 0, 0);
    chk_st("rst", IDLE_LO, 0);

    // release: first free edge captures i_raw, acceptance 5 edges later
    reset = 1'b0;
    step(5);
    chk_out("rel_pre", 0, 0, 0, 1);
    chk_st("rel_pre", WAIT_HI, 3);
    step(1);
    chk_out("rel_rise", 1, 1, 0, 0);
    step(1);
    chk_out("rel_post", 1, 0, 0, 0);
    chk_st("rel_post", IDLE_HI, 0);

    // clean fall
    i_raw = 1'b0;
    step(2);
    chk_out("fall_sync", 1, 0, 0, 0);
    step(1);
    chk_out("fall_busy", 1, 0, 0, 1);
    chk_st("fall_busy", WAIT_LO, 1);
    step(2);
    chk_out("fall_pre", 1, 0, 0, 1);
    chk_st("fall_pre", WAIT_LO, 3);
    step(1);
    chk_out("fall_acc", 0, 0, 1, 0);
    step(1);
    chk_out("fall_post", 0, 0, 0, 0);
    chk_st("fall_post", IDLE_LO, 0);

    // glitch: three high samples are one short of acceptance
    i_raw = 1'b1;
    step(3);
    chk_out("gl_busy", 0, 0, 0, 1);
    chk_st("gl_busy", WAIT_HI, 1);
    i_raw = 1'b0;
    step(2);
    chk_out("gl_pre", 0, 0, 0, 1);
    chk_st("gl_pre", WAIT_HI, 3);
    step(1);
    chk_out("gl_drop", 0, 0, 0, 0);
    chk_st("gl_drop", IDLE_LO, 0);
    step(1);
    chk_out("gl_post", 0, 0, 0, 0);

    // enable abort at cnt=2, then restart from 1
    i_raw = 1'b1;
    step(4);
    chk_st("ab_mid", WAIT_HI, 2);
    i_en = 1'b0;
    step(1);
    chk_out("ab_drop", 0, 0, 0, 0);
    chk_st("ab_drop", IDLE_LO, 0);
    step(2);
    chk_st("ab_hold", IDLE_LO, 0);
    i_en = 1'b1;
    step(1);
    chk_st("ab_restart", WAIT_HI, 1);
    step(2);
    chk_out("ab_pre", 0, 0, 0, 1);
    chk_st("ab_pre", WAIT_HI, 3);
    step(1);
    chk_out("ab_rise", 1, 1, 0, 0);
    step(1);
    chk_out("ab_post", 1, 0, 0, 0);

    // reset while counting a fall
    i_raw = 1'b0;
    step(5);
    chk_st("rm_mid", WAIT_LO, 3);
    reset = 1'b1;
    step(1);
    chk_out("rm_rst", 0, 0, 0, 0);
    chk_st("rm_rst", IDLE_LO, 0);
    step(1);
    chk_out("rm_rst2", 0, 0, 0, 0);
    reset = 1'b0;

    // unknown input while frozen must not reach the level
    i_en = 1'b0; i_raw = 1'bx;
    step(2);
    chk("x_level", {7'd0, o_level}, 8'd0);
    i_raw = 1'b0;
    step(3);
    i_en = 1'b1;
    step(1);
    chk_out("x_clean", 0, 0, 0, 0);

    // fast toggling: never accepted, busy pulses
    busy_seen = 0;
    for (int k = 0; k < 16; k++) begin
      i_raw = k[1];
      step(1);
      chk("tog_level", {7'd0, o_level}, 8'd0);
      chk("tog_rise",  {7'd0, o_rise},  8'd0);
      if (o_busy) busy_seen++;
    end
    chk("tog_busy_seen", 8'(busy_seen > 0), 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
